// File: rtl/dsp7_scan_driver.sv
// dsp7_scan_driver: multiplexed N-digit 7-segment driver with a double-buffered frame,
// BCD/hex decode, per-digit DP, anti-ghost blanking and optional leading-zero suppression.
module dsp7_scan_driver #(
   parameter int N_DIGITS   = 4,
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 2,
   parameter int HEX_MODE   = 1,
   parameter int SEG_ACT_LO = 1,
   parameter int AN_ACT_LO  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   digits_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    blank_lz,
   output logic                    pending,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [N_DIGITS-1:0]     an
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

   logic [DW-1:0]              div_cnt;
   logic [IW-1:0]              idx;
   logic [N_DIGITS-1:0][3:0]   shadow, display;
   logic [N_DIGITS-1:0]        dp_shadow, dp_disp, zero_up, an_nxt;
   logic                       tick, boundary, lit, supp, dp_lo;
   logic [3:0]                 cur;
   logic [6:0]                 seg_lo;

   function automatic logic [6:0] decode(input logic [3:0] c);
      logic [6:0] r;
      case (c)
         4'h0: r = 7'b1000000;
         4'h1: r = 7'b1111001;
         4'h2: r = 7'b0100100;
         4'h3: r = 7'b0110000;
         4'h4: r = 7'b0011001;
         4'h5: r = 7'b0010010;
         4'h6: r = 7'b0000010;
         4'h7: r = 7'b1111000;
         4'h8: r = 7'b0000000;
         4'h9: r = 7'b0011000;
         4'hA: r = 7'b0001000;
         4'hB: r = 7'b0000011;
         4'hC: r = 7'b1000110;
         4'hD: r = 7'b0100001;
         4'hE: r = 7'b0000110;
         default: r = 7'b0001110;
      endcase
      return (HEX_MODE == 0 && c > 4'd9) ? 7'b0111111 : r;
   endfunction

   // zero_up[i]: digit i and every more-significant digit are zero
   always_comb begin
      tick     = enable && div_cnt == DW'(CLK_DIV - 1);
      boundary = tick && idx == IW'(N_DIGITS - 1);
      lit      = enable && div_cnt >= DW'(BLANK_CYC);
      zero_up  = '0;
      zero_up[N_DIGITS-1] = display[N_DIGITS-1] == 4'd0;
      for (int i = N_DIGITS - 2; i >= 0; i--) zero_up[i] = zero_up[i+1] && display[i] == 4'd0;
      cur      = display[idx];
      supp     = blank_lz && idx != '0 && zero_up[idx];
      seg_lo   = (lit && !supp) ? decode(cur) : 7'h7F;
      dp_lo    = !(lit && dp_disp[idx]);
      an_nxt   = lit ? N_DIGITS'(1) << idx : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         idx       <= '0;
         shadow    <= '0;
         display   <= '0;
         dp_shadow <= '0;
         dp_disp   <= '0;
         pending   <= 1'b0;
         seg       <= {7{SEG_ACT_LO != 0}};
         dp        <= SEG_ACT_LO != 0;
         an        <= {N_DIGITS{AN_ACT_LO != 0}};
      end else begin
         if (enable) div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) idx <= boundary ? '0 : idx + 1'b1;
         if (boundary && pending) begin
            display <= shadow;
            dp_disp <= dp_shadow;
         end
         if (load) begin
            shadow    <= digits_in;
            dp_shadow <= dp_in;
            pending   <= 1'b1;
         end else if (boundary) begin
            pending   <= 1'b0;
         end
         seg <= (SEG_ACT_LO != 0) ? seg_lo : ~seg_lo;
         dp  <= (SEG_ACT_LO != 0) ? dp_lo : !dp_lo;
         an  <= (AN_ACT_LO != 0) ? ~an_nxt : an_nxt;
      end
   end
endmodule
